serial_in: RTL and testbench



---
 rtl/serial_pkg.sv | 18 +
 rtl/serial_in.sv | 91 +++++++++
 tb/tb_serial_in.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial_out / serial_in shifter pair:
// default frame width, receiver state encoding and counter-width derivation.
package serial_pkg;

   localparam int FRAME_W = 24;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RECV = 2'd2
   } state_t;

   // Bit-counter width for a frame of the given length.
   function automatic int cnt_w_of(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_in.sv
// Serial-to-parallel receiver for the serial_out shifter: MSB-first capture, one-cycle valid.
// Optional abort flag output enabled by defining SERIAL_IN_ABORT_FLAG_EN.
module serial_in
   import serial_pkg::*;
#(
   parameter int WIDTH = FRAME_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             din,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             busy
`ifdef SERIAL_IN_ABORT_FLAG_EN
   ,
   output logic             abort
`endif
);

   localparam int CNT_W = cnt_w_of(WIDTH);

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [WIDTH-1:0]   shreg, shreg_nx;
   logic [WIDTH-1:0]   dout_nx;
   logic               valid_nx;
`ifdef SERIAL_IN_ABORT_FLAG_EN
   logic               abort_nx;
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      shreg_nx = shreg;
      dout_nx  = dout;
      valid_nx = 1'b0;
`ifdef SERIAL_IN_ABORT_FLAG_EN
      abort_nx = 1'b0;
`endif
      if (start) begin
         // Frame sync wins in any state; a partial frame is dropped, dout kept.
         state_nx = LOAD;
         cnt_nx   = '0;
`ifdef SERIAL_IN_ABORT_FLAG_EN
         abort_nx = (state == RECV);
`endif
      end else if (state == LOAD || state == RECV) begin
         shreg_nx = {shreg[WIDTH-2:0], din};
         if (cnt == CNT_W'(WIDTH - 1)) begin
            dout_nx  = shreg_nx;
            valid_nx = 1'b1;
            state_nx = IDLE;
            cnt_nx   = '0;
         end else begin
            cnt_nx   = cnt + CNT_W'(1);
            state_nx = RECV;
         end
      end else begin
         state_nx = IDLE;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         // NOTE: shreg is cleared although it is fully refilled before use, so reset state is deterministic.
         shreg <= '0;
         dout  <= '0;
         valid <= 1'b0;
`ifdef SERIAL_IN_ABORT_FLAG_EN
         abort <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         shreg <= shreg_nx;
         dout  <= dout_nx;
         valid <= valid_nx;
`ifdef SERIAL_IN_ABORT_FLAG_EN
         abort <= abort_nx;
`endif
      end
   end

   assign busy = (state == LOAD) || (state == RECV);

endmodule

// File: tb/tb_serial_in.sv
// Self-checking bench for serial_in: upstream shifter model drives din, a bit-accumulating
// reference model is compared every cycle, directed scenarios pin literal words and timing.
module tb_serial_in;
   import serial_pkg::*;

   localparam int W = FRAME_W;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         din;
   logic [W-1:0] dout;
   logic         valid, busy;
   logic         start8 = 1'b0;
   logic         din8 = 1'b0;
   logic [7:0]   dout8;
   logic         valid8, busy8;
`ifdef SERIAL_IN_ABORT_FLAG_EN
   logic         abort, abort8;
`endif

   serial_in #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .din(din),
      .dout(dout), .valid(valid), .busy(busy)
`ifdef SERIAL_IN_ABORT_FLAG_EN
      , .abort(abort)
`endif
   );

   serial_in #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .din(din8),
      .dout(dout8), .valid(valid8), .busy(busy8)
`ifdef SERIAL_IN_ABORT_FLAG_EN
      , .abort(abort8)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int vcount = 0;
   int acount = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Upstream serial_out: loads on start, otherwise shifts left repeating its last bit.
   logic [W-1:0] bus_word = '0;
   logic [W-1:0] up_reg = '0;
   assign din = up_reg[W-1];
   always @(posedge clk) begin
      if (start) up_reg <= bus_word;
      else       up_reg <= {up_reg[W-2:0], up_reg[0]};
   end

   // Reference model: count sampled bits since the last start, assemble arithmetically.
   logic [W-1:0] m_dout;
   logic         m_valid, m_active, m_abort;
   int           m_n;
   longint       m_acc;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_dout <= '0; m_valid <= 1'b0; m_active <= 1'b0; m_abort <= 1'b0;
         m_n <= 0; m_acc <= 0;
      end else if (start) begin
         m_abort  <= m_active && (m_n > 0);
         m_active <= 1'b1;
         m_n      <= 0;
         m_acc    <= 0;
         m_valid  <= 1'b0;
      end else begin
         m_abort <= 1'b0;
         m_valid <= 1'b0;
         if (m_active) begin
            if (m_n + 1 == W) begin
               m_dout   <= W'(m_acc * 2 + longint'(din));
               m_valid  <= 1'b1;
               m_active <= 1'b0;
               m_n      <= 0;
            end else begin
               m_acc <= m_acc * 2 + longint'(din);
               m_n   <= m_n + 1;
            end
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("dout", dout, m_dout);
         check("valid", valid, m_valid);
         check("busy", busy, m_active);
`ifdef SERIAL_IN_ABORT_FLAG_EN
         check("abort", abort, m_abort);
         if (abort) acount <= acount + 1;
`endif
         if (valid) vcount <= vcount + 1;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Start high for 'hold' edges, then wait for valid; lat counts low-start edges.
   task automatic run_frame(input logic [W-1:0] word, input int hold,
                            output int lat, output int busy_n, output int vcyc);
      bus_word = word;
      start = 1'b1;
      busy_n = 0;
      lat = -1;
      vcyc = -1;
      for (int h = 0; h < hold; h++) begin
         tick();
         if (busy) busy_n++;
      end
      start = 1'b0;
      for (int i = 1; i <= W + 4; i++) begin
         tick();
         if (valid) begin
            lat = i;
            vcyc = cyc;
            break;
         end
         if (busy) busy_n++;
      end
   endtask

   task automatic partial(input logic [W-1:0] word, input int bits);
      bus_word = word;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (bits) tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bn, vc1, vc2, v0, a0, dummy;
      logic [W-1:0] w;
      logic [7:0] w8;

      rst = 1'b1;
      repeat (2) tick();
      check("rst_dout", dout, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      chk_en = 1'b1;
      tick();

      // Single frame, literal word and timing.
      v0 = vcount;
      run_frame(24'hA5C30F, 1, lat, bn, vc1);
      check("t1_lat", lat, W);
      check("t1_dout", dout, 24'hA5C30F);
      check("t1_model", m_dout, 24'hA5C30F);
      check("t1_busy_cycles", bn, W);
      tick();
      check("t1_valid_1cyc", valid, 0);
      check("t1_vcount", vcount, v0 + 1);

      // Back-to-back frames: start reasserted the cycle after valid.
      v0 = vcount;
      run_frame(24'h000001, 1, lat, bn, vc1);
      check("b2b_lat1", lat, W);
      check("b2b_dout1", dout, 24'h000001);
      run_frame(24'hFFFFFE, 1, lat, bn, vc2);
      check("b2b_lat2", lat, W);
      check("b2b_dout2", dout, 24'hFFFFFE);
      check("b2b_period", vc2 - vc1, W + 1);
      repeat (4) tick();
      check("b2b_vcount", vcount, v0 + 2);

      // Abort after 10 bits, from fresh reset so dout must stay 0.
      rst = 1'b1; tick(); rst = 1'b0; tick();
      v0 = vcount;
      a0 = acount;
      partial(24'h123456, 10);
      check("abort_dout_hold", dout, 0);
      run_frame(24'h654321, 1, lat, bn, vc1);
      check("abort_lat", lat, W);
      check("abort_dout", dout, 24'h654321);
      tick();
      check("abort_vcount", vcount, v0 + 1);
`ifdef SERIAL_IN_ABORT_FLAG_EN
      check("abort_pulses", acount, a0 + 1);
`endif

      // Asynchronous reset mid-frame.
      partial(24'hABCDEF, 12);
      rst = 1'b1;
      #1;
      check("arst_dout", dout, 0);
      check("arst_valid", valid, 0);
      check("arst_busy", busy, 0);
      tick();
      rst = 1'b0;
      tick();
      run_frame(24'hABCDEF, 1, lat, bn, vc1);
      check("arst_lat", lat, W);
      check("arst_dout_next", dout, 24'hABCDEF);

      // Start held 5 cycles, then trailing repeated zeros ignored.
      v0 = vcount;
      run_frame(24'h800000, 5, lat, bn, vc1);
      check("hold_lat", lat, W);
      check("hold_dout", dout, 24'h800000);
      check("hold_busy_cycles", bn, 5 + W - 1);
      repeat (30) tick();
      check("hold_vcount", vcount, v0 + 1);
      check("hold_dout_kept", dout, 24'h800000);

      // Randomised frames with occasional aborts (including on the last sample edge).
      for (int k = 0; k < 60; k++) begin
         w = W'($urandom);
         if ($urandom_range(0, 3) == 0)
            partial(W'($urandom), $urandom_range(1, W - 1));
         run_frame(w, $urandom_range(1, 3), lat, bn, dummy);
         check("rnd_lat", lat, W);
         check("rnd_dout", dout, w);
         repeat ($urandom_range(0, 3)) tick();
      end

      // WIDTH=8 instance.
      w8 = 8'h5A;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         din8 = w8[7 - i];
         tick();
         check("w8_valid", valid8, (i == 7));
      end
      check("w8_dout", dout8, 8'h5A);
      tick();
      check("w8_valid_1cyc", valid8, 0);
      check("w8_busy_idle", busy8, 0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
